// File: rtl/pushbutton_processor_if.sv
// -----------------------------------------------------------------------------
// pushbutton_processor_if
// Groups the pushbutton signals of pushbutton_processor into one bundle.
//   pushbutton_i : raw asynchronous button level, 1 = pressed (may bounce)
//   count_up     : one-cycle pulse, short press completed
//   count_down   : one-cycle pulse, long-press threshold reached
// Modports:
//   master : the side that owns the button and consumes the command pulses
//   slave  : the processor itself
// -----------------------------------------------------------------------------
interface pushbutton_processor_if;
  logic pushbutton_i;
  logic count_up;
  logic count_down;

  modport master (
    output pushbutton_i,
    input  count_up,
    input  count_down
  );

  modport slave (
    input  pushbutton_i,
    output count_up,
    output count_down
  );
endinterface

// File: rtl/pushbutton_processor.sv
// -----------------------------------------------------------------------------
// pushbutton_processor
// Turns one raw mechanical pushbutton into two single-cycle command pulses for
// the scoreboard counter. The button is synchronized, debounced and then timed:
// a short press yields count_up on release, a long press yields count_down
// while the button is still held. Everything runs on the 1 kHz clock, so one
// cycle is one millisecond.
//
// Parameters:
//   DEBOUNCE_MS   : consecutive differing samples needed to move the
//                   debounced level
//   LONG_PRESS_MS : debounced-high cycles after which a press counts as long
// Ports:
//   clk_1khz : 1 kHz system clock, rising edge
//   rst      : synchronous, active-high reset
//   bus      : pushbutton_processor_if.slave (pushbutton_i in,
//              count_up / count_down out, both registered)
// -----------------------------------------------------------------------------
module pushbutton_processor #(
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 2000
) (
  input  logic                   clk_1khz,
  input  logic                   rst,
  pushbutton_processor_if.slave  bus
);

  localparam int DEB_W  = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_MS + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  logic              sync_ff1;
  logic              sync;
  logic              deb;
  logic [DEB_W-1:0]  stable_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  state_t            state;
  logic              up_pulse;
  logic              down_pulse;

  // Two-flop synchronizer; only sync is used downstream.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      sync     <= 1'b0;
    end else begin
      sync_ff1 <= bus.pushbutton_i;
      sync     <= sync_ff1;
    end
  end

  // The counter runs only while sync disagrees with deb. The DEBOUNCE_MS-th
  // consecutive disagreeing sample flips deb instead of incrementing, so any
  // agreeing sample before that throws the partial run away.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      deb        <= 1'b0;
      stable_cnt <= '0;
    end else if (sync == deb) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DEB_LAST) begin
      deb        <= ~deb;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + DEB_ONE;
    end
  end

  // Press timing FSM. Pulses default low so each lasts one cycle. In PRESSED
  // the release test comes first, so a release on the threshold edge still
  // counts as a short press. count_down is launched on the edge where the
  // hold counter reaches LONG_PRESS_MS-1, which places the pulse exactly
  // LONG_PRESS_MS cycles after deb rose.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
    end else begin
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (deb) begin
            hold_cnt <= '0;
            state    <= PRESSED;
          end
        end
        PRESSED: begin
          if (!deb) begin
            up_pulse <= 1'b1;
            state    <= IDLE;
          end else if (hold_cnt + HOLD_ONE == HOLD_LAST) begin
            hold_cnt   <= HOLD_LAST;
            down_pulse <= 1'b1;
            state      <= LONG_HELD;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        LONG_HELD: begin
          if (!deb) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.count_up   = up_pulse;
  assign bus.count_down = down_pulse;

endmodule

// File: tb/tb_pushbutton_processor.sv
// -----------------------------------------------------------------------------
// tb_pushbutton_processor
// Self-checking bench for pushbutton_processor. Each run plays a per-cycle raw
// button waveform and records both outputs every cycle. A reference model
// works out the debounced level from sample windows and then classifies every
// debounced press by its length to decide which pulse is due and on which
// cycle. Directed runs add hand-derived pulse totals and latencies.
// -----------------------------------------------------------------------------
module tb_pushbutton_processor;

  localparam int DEBOUNCE_MS   = 20;
  localparam int LONG_PRESS_MS = 2000;
  localparam int MAX_LEN       = 4096;

  logic clk_1khz = 1'b0;
  logic rst      = 1'b1;

  int n_checks   = 0;
  int n_failures = 0;

  logic stim      [MAX_LEN];
  logic obs_up    [MAX_LEN];
  logic obs_down  [MAX_LEN];
  logic exp_up    [MAX_LEN];
  logic exp_down  [MAX_LEN];
  logic deb_model [MAX_LEN];
  int   stim_len = 0;

  int mark_idx;

  pushbutton_processor_if bus ();

  pushbutton_processor #(
    .DEBOUNCE_MS   (DEBOUNCE_MS),
    .LONG_PRESS_MS (LONG_PRESS_MS)
  ) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_1khz = ~clk_1khz;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic addLevel(input logic level, input int len);
    for (int i = 0; i < len; i++) begin
      if (stim_len < MAX_LEN) begin
        stim[stim_len] = level;
        stim_len++;
      end
    end
  endtask

  // Holds reset for the given number of edges with the button at 'level';
  // both outputs must read 0 after every reset edge.
  task automatic doReset(input int cycles, input logic level);
    rst = 1'b1;
    bus.pushbutton_i = level;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_1khz);
      checkOutput("reset_count_up", bus.count_up, 32'd0);
      checkOutput("reset_count_down", bus.count_down, 32'd0);
    end
    rst = 1'b0;
  endtask

  // Drives stim[t] ahead of edge t and records the outputs after that edge.
  task automatic applyStimulus();
    for (int t = 0; t < stim_len; t++) begin
      bus.pushbutton_i = stim[t];
      @(negedge clk_1khz);
      obs_up[t]   = bus.count_up;
      obs_down[t] = bus.count_down;
    end
  endtask

  // The sample seen by the debouncer at edge t is the raw level from two
  // edges earlier. The debounced level flips once the last DEBOUNCE_MS
  // samples all disagree with it. A press whose debounced high time is
  // shorter than LONG_PRESS_MS earns count_up one cycle after the debounced
  // fall; otherwise count_down lands LONG_PRESS_MS cycles after the rise.
  task automatic runModel();
    logic level;
    logic prev;
    logic s;
    bit   flip;
    int   idx;
    int   fall;
    level = 1'b0;
    for (int t = 0; t < stim_len; t++) begin
      flip = (t >= DEBOUNCE_MS - 1);
      for (int j = 0; j < DEBOUNCE_MS; j++) begin
        idx = t - j;
        s = (idx >= 2) ? stim[idx-2] : 1'b0;
        if (s == level) flip = 1'b0;
      end
      if (flip) level = ~level;
      deb_model[t] = level;
      exp_up[t]    = 1'b0;
      exp_down[t]  = 1'b0;
    end
    prev = 1'b0;
    for (int t = 0; t < stim_len; t++) begin
      if (deb_model[t] && !prev) begin
        fall = -1;
        for (int u = t + 1; u < stim_len && fall < 0; u++) begin
          if (!deb_model[u]) fall = u;
        end
        if (fall >= 0 && (fall - t) < LONG_PRESS_MS) begin
          if (fall + 1 < stim_len) exp_up[fall+1] = 1'b1;
        end else if (t + LONG_PRESS_MS < stim_len) begin
          exp_down[t+LONG_PRESS_MS] = 1'b1;
        end
      end
      prev = deb_model[t];
    end
  endtask

  // Compares the recorded run against the model; want_up/want_down give
  // hand-derived pulse totals for directed runs, or -1 when there are none.
  task automatic compareRun(input string tag, input int want_up, input int want_down);
    int up_obs;
    int up_exp;
    int dn_obs;
    int dn_exp;
    int both;
    int first_diff;
    up_obs = 0; up_exp = 0; dn_obs = 0; dn_exp = 0; both = 0; first_diff = -1;
    runModel();
    for (int t = 0; t < stim_len; t++) begin
      if (obs_up[t] === 1'b1) up_obs++;
      if (obs_down[t] === 1'b1) dn_obs++;
      if (exp_up[t]) up_exp++;
      if (exp_down[t]) dn_exp++;
      if (obs_up[t] === 1'b1 && obs_down[t] === 1'b1) both++;
      if (first_diff < 0 && (obs_up[t] !== exp_up[t] || obs_down[t] !== exp_down[t]))
        first_diff = t;
    end
    checkOutput({tag, "_up_pulses"}, up_obs, up_exp);
    checkOutput({tag, "_down_pulses"}, dn_obs, dn_exp);
    checkOutput({tag, "_first_bad_cycle"}, first_diff, -1);
    checkOutput({tag, "_both_high"}, both, 32'd0);
    if (want_up >= 0) checkOutput({tag, "_up_total"}, up_obs, want_up);
    if (want_down >= 0) checkOutput({tag, "_down_total"}, dn_obs, want_down);
  endtask

  function automatic int firstPulse(input bit want_up);
    for (int t = 0; t < stim_len; t++) begin
      if (want_up && obs_up[t] === 1'b1) return t;
      if (!want_up && obs_down[t] === 1'b1) return t;
    end
    return -1;
  endfunction

  initial begin
    bus.pushbutton_i = 1'b0;
    doReset(3, 1'b0);

    $display("[TB] bouncy short press");
    stim_len = 0;
    addLevel(1'b0, 10);
    addLevel(1'b1, 1);
    addLevel(1'b0, 2);
    addLevel(1'b1, 2);
    addLevel(1'b0, 1);
    addLevel(1'b1, 32);
    mark_idx = stim_len;
    addLevel(1'b0, 50);
    applyStimulus();
    compareRun("bouncy", 1, 0);
    checkOutput("bouncy_up_latency", firstPulse(1'b1) - mark_idx, DEBOUNCE_MS + 2);

    $display("[TB] long press");
    doReset(2, 1'b0);
    stim_len = 0;
    addLevel(1'b0, 20);
    mark_idx = stim_len;
    addLevel(1'b1, 2130);
    addLevel(1'b0, 50);
    applyStimulus();
    compareRun("long", 0, 1);
    checkOutput("long_down_latency", firstPulse(1'b0) - mark_idx,
                DEBOUNCE_MS + 1 + LONG_PRESS_MS);

    $display("[TB] glitch rejection");
    doReset(2, 1'b0);
    stim_len = 0;
    addLevel(1'b0, 10);
    for (int k = 0; k < 6; k++) begin
      addLevel(1'b1, DEBOUNCE_MS - 1);
      addLevel(1'b0, DEBOUNCE_MS - 1);
    end
    addLevel(1'b0, 30);
    applyStimulus();
    compareRun("glitch", 0, 0);

    $display("[TB] threshold minus one");
    doReset(2, 1'b0);
    stim_len = 0;
    addLevel(1'b0, 10);
    addLevel(1'b1, LONG_PRESS_MS - 1);
    mark_idx = stim_len;
    addLevel(1'b0, 50);
    applyStimulus();
    compareRun("thr_short", 1, 0);
    checkOutput("thr_short_up_latency", firstPulse(1'b1) - mark_idx, DEBOUNCE_MS + 2);

    $display("[TB] threshold exact");
    doReset(2, 1'b0);
    stim_len = 0;
    addLevel(1'b0, 10);
    mark_idx = stim_len;
    addLevel(1'b1, LONG_PRESS_MS);
    addLevel(1'b0, 50);
    applyStimulus();
    compareRun("thr_long", 0, 1);
    checkOutput("thr_long_down_latency", firstPulse(1'b0) - mark_idx,
                DEBOUNCE_MS + 1 + LONG_PRESS_MS);

    $display("[TB] reset mid-press");
    doReset(2, 1'b0);
    stim_len = 0;
    addLevel(1'b0, 10);
    addLevel(1'b1, 1000);
    applyStimulus();
    compareRun("pre_reset", 0, 0);
    doReset(3, 1'b1);
    stim_len = 0;
    addLevel(1'b1, 2100);
    addLevel(1'b0, 50);
    applyStimulus();
    compareRun("post_reset", 0, 1);
    checkOutput("post_reset_down_latency", firstPulse(1'b0),
                DEBOUNCE_MS + 1 + LONG_PRESS_MS);

    $display("[TB] back-to-back presses");
    doReset(2, 1'b0);
    stim_len = 0;
    addLevel(1'b0, 10);
    addLevel(1'b1, 100);
    addLevel(1'b0, 100);
    addLevel(1'b1, 100);
    addLevel(1'b0, 50);
    applyStimulus();
    compareRun("back2back", 2, 0);

    for (int r = 0; r < 4; r++) begin
      $display("[TB] random run %0d", r);
      doReset(2, 1'b0);
      stim_len = 0;
      addLevel(1'b0, 10);
      for (int k = 0; k < 20; k++) begin
        if (k == 10) addLevel(1'b1, int'($urandom_range(LONG_PRESS_MS - 5, LONG_PRESS_MS + 5)));
        addLevel(logic'(k % 2 == 0), int'($urandom_range(1, 45)));
      end
      addLevel(1'b0, 60);
      applyStimulus();
      compareRun($sformatf("random%0d", r), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/pushbutton_processor.md
Name: pushbutton_processor

Overview:
- Converts one raw mechanical pushbutton into two single-cycle command pulses for the scoreboard counter logic.
- Synchronizes and debounces the button, then measures how long it is held.
- A short press (released before LONG_PRESS_MS) gives count_up on release.
- A long press (held LONG_PRESS_MS) gives count_down while still held.
- Runs entirely in the 1 kHz clock domain, so 1 cycle = 1 ms.

Parameters:
- DEBOUNCE_MS, 20, consecutive stable synchronized samples needed before the debounced level changes.
- LONG_PRESS_MS, 2000, debounced-high cycles after which a press counts as long.

Ports:
- clk_1khz  input  1  1 kHz system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pushbutton_i  input  1  raw asynchronous button, 1 = pressed, may bounce.
- count_up  output  1  one-cycle pulse: short press completed.
- count_down  output  1  one-cycle pulse: long-press threshold reached.

Behaviour:
- Reset:
  - Reset is synchronous and active-high. While rst=1 at a clock edge, all state clears: synchronizer flops 0, debounced level 0, counters 0, FSM IDLE, count_up=0, count_down=0.
  - If the button is still held when reset releases, it is treated as a new press: debounce restarts from level 0.
- Synchronizer:
  - Two-flop synchronizer on pushbutton_i, giving 2 cycles of latency.
  - Only the synchronized signal (sync) is used downstream.
- Debouncer:
  - deb is the registered debounced level.
  - While sync == deb, the stability counter holds at 0.
  - While sync != deb, the counter increments each cycle.
  - On the edge where the counter would reach DEBOUNCE_MS, deb toggles and the counter clears. So deb follows sync after DEBOUNCE_MS consecutive differing samples.
  - Any sample with sync == deb before then clears the counter, so glitches shorter than DEBOUNCE_MS cycles are ignored.
  - Counter width is $clog2(DEBOUNCE_MS+1).
- Press FSM, clocked on deb:
  - IDLE: deb rises -> PRESSED, hold counter cleared to 0.
  - PRESSED: hold counter increments each cycle.
    - If deb falls before the counter reaches LONG_PRESS_MS: count_up=1 for exactly the next cycle, then -> IDLE.
    - When the counter reaches LONG_PRESS_MS-1 with deb still high: count_down=1 for exactly the next cycle, then -> LONG_HELD.
    - So count_down asserts LONG_PRESS_MS cycles after the deb rising edge.
  - LONG_HELD: counter frozen, no output. deb falls -> IDLE with no count_up.
- Hold counter: width $clog2(LONG_PRESS_MS+1), saturating, never wraps.
- Outputs:
  - count_up and count_down are registered and never high in the same cycle.
  - Each press produces exactly one pulse total: count_up or count_down, never both.
- Overall latency:
  - count_up is about 2 + DEBOUNCE_MS + 1 cycles after the raw release.
  - count_down is about 2 + DEBOUNCE_MS + LONG_PRESS_MS cycles after the raw press.
- Boundary cases:
  - Release on the same edge the counter hits LONG_PRESS_MS-1: count_up wins (release checked first).
  - Held exactly LONG_PRESS_MS-1 debounced cycles: short press.
  - Reset during PRESSED or LONG_HELD: no pulse emitted; state goes to IDLE.

Test Plan:
- Bouncy short press: idle 10 ms; pulses of 1 ms high, 2 ms low, 2 ms high, 1 ms low, 2 ms high; then hold 30 ms; release; wait 50 ms. Required: exactly one count_up pulse of 1 cycle, about 23 ms after release. count_down stays 0. No pulses during the bounce.
- Long press: hold 2130 ms, release, wait 50 ms. Required: exactly one count_down pulse, 2000 cycles after the debounced rise (about 2022 ms after press). No count_up on release.
- Glitch rejection: single 19 ms high pulse, then 19 ms low gaps repeated. Required: deb stays 0; no pulses.
- Threshold boundary: debounced hold of 1999 cycles gives one count_up. Hold of 2000 cycles gives one count_down and no count_up.
- Reset mid-operation: assert rst for 3 cycles 1000 ms into a hold, then keep the button held 2100 ms more. Required: outputs 0 during and after reset. count_down occurs 2000 cycles after the re-debounced rise. No stray count_up.
- Back-to-back: two 100 ms presses separated by 100 ms. Required: exactly two count_up pulses.
